vid_timing_gen: RTL
===================

Name: vid_timing_gen

Overview:
- Parametrised raster timing generator for the video controller datapath.
- Consumes the programmed cr/h1/h2/v1/v2 fields: en, pcnt, hsize/hend, hsync window, vsize/vend, vsync window.
- Produces hsync/hblank/vsync/vblank, a display-enable, and a one-per-pixel FIFO read strobe that drains the RGB pixel FIFOs.
- Adds features the current controller lacks: shadowed config applied only at frame boundaries, a pixel clock divider, config validity checking, parametrised counter width and sync polarity, and line/frame markers.

Parameters:
CW, 13, width of all horizontal/vertical position fields and counters
DW, 6, width of pixel divider field pcnt
FW, 8, width of frame counter output
HSYNC_POL, 1, 1 = hsync active-high, 0 = active-low
VSYNC_POL, 1, 1 = vsync active-high, 0 = active-low

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
en  in  1  controller enable (cr.en)
pcnt  in  DW  pixel divider; one pixel tick every pcnt+1 clocks
hsize  in  CW  displayed pixels per line
hend  in  CW  last pixel index of line (line length = hend+1)
hsync_start  in  CW  first pixel index with hsync active
hsync_end  in  CW  first pixel index with hsync inactive again
vsize  in  CW  displayed lines per frame
vend  in  CW  last line index (frame height = vend+1)
vsync_start  in  CW  first line index with vsync active
vsync_end  in  CW  first line index with vsync inactive again
hcount  out  CW  current pixel index
vcount  out  CW  current line index
hsync  out  1  horizontal sync, polarity per HSYNC_POL
hblank  out  1  1 when hcount >= hsize
vsync  out  1  vertical sync, polarity per VSYNC_POL
vblank  out  1  1 when vcount >= vsize
de  out  1  display enable = ~hblank & ~vblank
pix_rd  out  1  one-clock pulse per displayed pixel; drives FIFO read
line_start  out  1  one-clock pulse when hcount becomes 0
frame_start  out  1  one-clock pulse when (hcount,vcount) becomes (0,0)
frame_cnt  out  FW  completed frames, wraps modulo 2^FW
cfg_err  out  1  sticky; the last config load was invalid

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: state=IDLE. hcount, vcount, div counter, frame_cnt, hblank, vblank, de, pix_rd, line_start, frame_start and cfg_err are all 0. hsync is ~HSYNC_POL. vsync is ~VSYNC_POL. Reset mid-frame aborts the frame immediately.
- FSM states: IDLE, LOAD, RUN.
- IDLE: all outputs hold their reset values, except frame_cnt and cfg_err, which hold. On en=1, go to LOAD.
- LOAD (1 clk): copy all config inputs into shadow registers. The config is valid iff all of the following hold:
  - hsize <= hend
  - vsize <= vend
  - hsync_start <= hsync_end <= hend+1
  - vsync_start <= vsync_end <= vend+1
  - Valid: cfg_err<=0, go to RUN with counters at (0,0).
  - Invalid: cfg_err<=1, return to IDLE. It cannot re-leave IDLE until en goes 0 and then 1 again.
- RUN: the divider counts 0..pcnt_shadow. tick is asserted when the divider equals pcnt_shadow, after which the divider wraps to 0. With pcnt=0, tick fires every clock.
- On each tick: hcount increments. At hcount==hend it wraps to 0 and vcount increments. At vcount==vend together with the hcount wrap, vcount wraps to 0, frame_cnt increments, and the shadow registers reload from the inputs with the validity check re-run. If the reload is invalid: cfg_err=1, go to IDLE.
- Config input changes mid-frame have no effect until the frame boundary.
- Output timing: all outputs are registered and update on the same edge as the counters, reflecting the new counter values.
  - hsync is active iff hsync_start <= hcount < hsync_end.
  - vsync is active iff vsync_start <= vcount < vsync_end.
  - Equal start/end gives a sync that is never active.
- Pulses: pix_rd, line_start and frame_start are high for exactly one clk, and only on the clock of the corresponding tick. pix_rd=1 iff the tick lands on a position with de=1. Per valid frame, pix_rd count = hsize*vsize.
- en=0 while in RUN: next clk go to IDLE and drive reset values (frame_cnt holds). en=1 again: LOAD, restart at (0,0).
- Arithmetic: all comparisons are unsigned, CW bits wide. hend+1 and vend+1 are evaluated at CW+1 bits. frame_cnt wraps with no flag.

Test Plan:
- Basic raster: hsize=4, hend=5, hsync 4..5, vsize=2, vend=3, vsync 2..3, pcnt=0, en=1 -> frame_start every 24 clks; 8 pix_rd per frame; hsync high 1 clk/line; vsync high for 6 clks (line 2); de pattern 1111_00 on lines 0–1.
- Divider: same config with pcnt=2 -> every counter step and pulse spaced 3 clks; frame period 72 clks; pix_rd still 8 per frame.
- Invalid config: hsize=7, hend=5 -> after LOAD, cfg_err=1, state IDLE, no pix_rd. Toggle en with a valid config -> cfg_err=0, raster starts.
- Shadowing: change hsize 4->2 at hcount=1 of line 1 -> current frame still gives 8 pix_rd; next frame gives 4.
- Polarity and wrap: HSYNC_POL=0, VSYNC_POL=0, FW=2 -> syncs idle high and pulse low; after 4 frames frame_cnt wraps 3->0.
- Reset/enable mid-frame: reset at vcount=1 -> next clk all outputs at reset values. en drop mid-line -> IDLE in 1 clk, frame_cnt held; restart begins at (0,0) with frame_start.

Source files
------------

// File: rtl/vid_timing_gen_if.sv
// Raster timing bundle: programmed config in, timing and strobes out.
// The generator takes the slave side.
interface vid_timing_gen_if #(
  parameter int CW = 13,
  parameter int DW = 6,
  parameter int FW = 8
);
  logic          en;
  logic [DW-1:0] pcnt;
  logic [CW-1:0] hsize;
  logic [CW-1:0] hend;
  logic [CW-1:0] hsync_start;
  logic [CW-1:0] hsync_end;
  logic [CW-1:0] vsize;
  logic [CW-1:0] vend;
  logic [CW-1:0] vsync_start;
  logic [CW-1:0] vsync_end;
  logic [CW-1:0] hcount;
  logic [CW-1:0] vcount;
  logic          hsync;
  logic          hblank;
  logic          vsync;
  logic          vblank;
  logic          de;
  logic          pix_rd;
  logic          line_start;
  logic          frame_start;
  logic [FW-1:0] frame_cnt;
  logic          cfg_err;

  modport master (
    output en, pcnt, hsize, hend,
    output hsync_start, hsync_end,
    output vsize, vend,
    output vsync_start, vsync_end,
    input  hcount, vcount, hsync, hblank,
    input  vsync, vblank, de, pix_rd,
    input  line_start, frame_start,
    input  frame_cnt, cfg_err
  );

  modport slave (
    input  en, pcnt, hsize, hend,
    input  hsync_start, hsync_end,
    input  vsize, vend,
    input  vsync_start, vsync_end,
    output hcount, vcount, hsync, hblank,
    output vsync, vblank, de, pix_rd,
    output line_start, frame_start,
    output frame_cnt, cfg_err
  );
endinterface

// File: rtl/vid_timing_gen.sv
// Raster timing generator with shadowed config, pixel divider,
// config checking and line/frame markers.
module vid_timing_gen #(
  parameter int CW        = 13,
  parameter int DW        = 6,
  parameter int FW        = 8,
  parameter int HSYNC_POL = 1,
  parameter int VSYNC_POL = 1
) (
  input logic        clk,
  input logic        reset,
  vid_timing_gen_if.slave vt
);

  localparam logic HP = (HSYNC_POL != 0);
  localparam logic VP = (VSYNC_POL != 0);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  typedef struct packed {
    logic [DW-1:0] pcnt;
    logic [CW-1:0] hsize;
    logic [CW-1:0] hend;
    logic [CW-1:0] hss;
    logic [CW-1:0] hse;
    logic [CW-1:0] vsize;
    logic [CW-1:0] vend;
    logic [CW-1:0] vss;
    logic [CW-1:0] vse;
  } cfg_t;

  state_t        state_d, state_q;
  cfg_t          cfg_in, cfg_d, cfg_q;
  logic [DW-1:0] div_d, div_q;
  logic [CW-1:0] hcnt_d, hcnt_q;
  logic [CW-1:0] vcnt_d, vcnt_q;
  logic [FW-1:0] frm_d, frm_q;
  logic          hs_d, hs_q, hb_d, hb_q;
  logic          vs_d, vs_q, vb_d, vb_q;
  logic          de_d, de_q, pix_d, pix_q;
  logic          ls_d, ls_q, fs_d, fs_q;
  logic          err_d, err_q;
  logic          hold_d, hold_q;
  logic          cfg_ok, step, idle_out;
  logic [CW:0]   hend_p1, vend_p1;

  assign cfg_in = {
    vt.pcnt, vt.hsize, vt.hend,
    vt.hsync_start, vt.hsync_end,
    vt.vsize, vt.vend,
    vt.vsync_start, vt.vsync_end
  };

  // Validity of the live config inputs; end+1 kept one bit wider.
  always_comb begin
    hend_p1 = {1'b0, cfg_in.hend} + (CW+1)'(1);
    vend_p1 = {1'b0, cfg_in.vend} + (CW+1)'(1);
    cfg_ok  = (cfg_in.hsize <= cfg_in.hend)
           && (cfg_in.vsize <= cfg_in.vend)
           && (cfg_in.hss <= cfg_in.hse)
           && ({1'b0, cfg_in.hse} <= hend_p1)
           && (cfg_in.vss <= cfg_in.vse)
           && ({1'b0, cfg_in.vse} <= vend_p1);
  end

  // Next state, counters and registered outputs for the new position.
  always_comb begin
    state_d  = state_q;
    cfg_d    = cfg_q;
    div_d    = div_q;
    hcnt_d   = hcnt_q;
    vcnt_d   = vcnt_q;
    frm_d    = frm_q;
    err_d    = err_q;
    hold_d   = hold_q;
    hs_d     = hs_q;
    hb_d     = hb_q;
    vs_d     = vs_q;
    vb_d     = vb_q;
    de_d     = de_q;
    pix_d    = 1'b0;
    ls_d     = 1'b0;
    fs_d     = 1'b0;
    step     = 1'b0;
    idle_out = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!vt.en) hold_d = 1'b0;
        else if (!hold_q) state_d = LOAD;
      end
      LOAD: begin
        cfg_d  = cfg_in;
        div_d  = '0;
        hcnt_d = '0;
        vcnt_d = '0;
        if (cfg_ok) begin
          err_d   = 1'b0;
          state_d = RUN;
          step    = 1'b1;
        end else begin
          err_d   = 1'b1;
          hold_d  = 1'b1;
          state_d = IDLE;
        end
      end
      RUN: begin
        if (!vt.en) begin
          state_d  = IDLE;
          idle_out = 1'b1;
        end else if (div_q != cfg_q.pcnt) begin
          div_d = div_q + DW'(1);
        end else begin
          div_d = '0;
          step  = 1'b1;
          if (hcnt_q != cfg_q.hend) begin
            hcnt_d = hcnt_q + CW'(1);
          end else begin
            hcnt_d = '0;
            if (vcnt_q != cfg_q.vend) begin
              vcnt_d = vcnt_q + CW'(1);
            end else begin
              vcnt_d = '0;
              frm_d  = frm_q + FW'(1);
              cfg_d  = cfg_in;
              if (cfg_ok) begin
                err_d = 1'b0;
              end else begin
                err_d    = 1'b1;
                hold_d   = 1'b1;
                state_d  = IDLE;
                step     = 1'b0;
                idle_out = 1'b1;
              end
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (step) begin
      hb_d  = hcnt_d >= cfg_d.hsize;
      vb_d  = vcnt_d >= cfg_d.vsize;
      de_d  = !hb_d && !vb_d;
      hs_d  = (hcnt_d >= cfg_d.hss && hcnt_d < cfg_d.hse) ? HP : ~HP;
      vs_d  = (vcnt_d >= cfg_d.vss && vcnt_d < cfg_d.vse) ? VP : ~VP;
      pix_d = de_d;
      ls_d  = (hcnt_d == '0);
      fs_d  = ls_d && (vcnt_d == '0);
    end
    if (idle_out) begin
      div_d  = '0;
      hcnt_d = '0;
      vcnt_d = '0;
      hb_d   = 1'b0;
      vb_d   = 1'b0;
      de_d   = 1'b0;
      hs_d   = ~HP;
      vs_d   = ~VP;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cfg_q   <= '0;
      div_q   <= '0;
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      frm_q   <= '0;
      err_q   <= 1'b0;
      hold_q  <= 1'b0;
      hs_q    <= ~HP;
      hb_q    <= 1'b0;
      vs_q    <= ~VP;
      vb_q    <= 1'b0;
      de_q    <= 1'b0;
      pix_q   <= 1'b0;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      div_q   <= div_d;
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      frm_q   <= frm_d;
      err_q   <= err_d;
      hold_q  <= hold_d;
      hs_q    <= hs_d;
      hb_q    <= hb_d;
      vs_q    <= vs_d;
      vb_q    <= vb_d;
      de_q    <= de_d;
      pix_q   <= pix_d;
      ls_q    <= ls_d;
      fs_q    <= fs_d;
    end
  end

  assign vt.hcount      = hcnt_q;
  assign vt.vcount      = vcnt_q;
  assign vt.hsync       = hs_q;
  assign vt.hblank      = hb_q;
  assign vt.vsync       = vs_q;
  assign vt.vblank      = vb_q;
  assign vt.de          = de_q;
  assign vt.pix_rd      = pix_q;
  assign vt.line_start  = ls_q;
  assign vt.frame_start = fs_q;
  assign vt.frame_cnt   = frm_q;
  assign vt.cfg_err     = err_q;

endmodule
